// File: rtl/gray_to_bin_pipe_if.sv
// Stream bundle for the pipelined Gray-to-binary decoder: Gray words in,
// binary words plus multi-bit-change flag out, valid/ready on both sides.
`timescale 1ns/1ps
interface gray_to_bin_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_gray;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_bin;
   logic             out_err;

   // Decoder side
   modport slave (
      input  in_valid, in_gray, out_ready,
      output in_ready, out_valid, out_bin, out_err
   );

   // Producer/consumer side
   modport master (
      output in_valid, in_gray, out_ready,
      input  in_ready, out_valid, out_bin, out_err
   );
endinterface

// File: rtl/gray_to_bin_pipe.sv
// Pipelined Gray-to-binary decoder: the XOR prefix chain is cut into STAGES
// slices, MSB slice first, with an elastic valid/ready pipeline around it.
`timescale 1ns/1ps
module gray_to_bin_pipe #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned STAGES   = 2,
   parameter bit          CHECK_EN = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   gray_to_bin_pipe_if.slave bus
);
   localparam int unsigned SLICE = (WIDTH + STAGES - 1) / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] err;
   logic [WIDTH-1:0]  data [STAGES];
   logic [WIDTH-1:0]  res  [STAGES];
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] src_err;
   logic              err0;

   // Resolve bits [hi:lo] of a partly decoded word; bits above hi are already binary.
   function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] w,
                                                input int hi, input int lo);
      logic [WIDTH-1:0] r;
      logic             carry;
      r     = w;
      carry = 1'b0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (i <= hi && i >= lo) r[i] = carry ^ w[i];
         carry = r[i];
      end
      return r;
   endfunction

   for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
      localparam int HI     = int'(WIDTH) - 1 - s * int'(SLICE);
      localparam int LO_RAW = int'(WIDTH) - (s + 1) * int'(SLICE);
      localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;
      if (s == 0) begin : g_head
         assign res[s] = resolve(bus.in_gray, HI, LO);
      end else begin : g_tail
         assign res[s] = resolve(data[s-1], HI, LO);
      end
   end

   // Advance chain: a stage may load when its word leaves or it is empty.
   always_comb begin
      logic [STAGES-1:0] a;
      a       = '0;
      a[LAST] = bus.out_ready | ~v[LAST];
      for (int s = int'(LAST) - 1; s >= 0; s--) begin
         a[s] = a[s+1] | ~v[s];
      end
      adv = a;
   end

   always_comb begin
      src_v      = '0;
      src_err    = '0;
      src_v[0]   = bus.in_valid;
      src_err[0] = err0;
      for (int s = 1; s < int'(STAGES); s++) begin
         src_v[s]   = v[s-1];
         src_err[s] = err[s-1];
      end
   end

   // Data only loads with a valid word, so idle input values never reach the output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v   <= '0;
         err <= '0;
         for (int s = 0; s < int'(STAGES); s++) data[s] <= '0;
      end else begin
         for (int s = 0; s < int'(STAGES); s++) begin
            if (adv[s]) begin
               v[s] <= src_v[s];
               if (src_v[s]) begin
                  data[s] <= res[s];
                  err[s]  <= src_err[s];
               end
            end
         end
      end
   end

   if (CHECK_EN) begin : g_chk
      logic [WIDTH-1:0] prev_gray;
      logic             prev_ok;
      logic [WIDTH-1:0] diff;
      logic             in_xfer;

      assign in_xfer = bus.in_valid & adv[0];
      assign diff    = bus.in_gray ^ prev_gray;
      // More than one bit set <=> clearing the lowest set bit leaves something.
      assign err0    = prev_ok & ((diff & (diff - WIDTH'(1))) != '0);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            prev_gray <= '0;
            prev_ok   <= 1'b0;
         end else if (in_xfer) begin
            prev_gray <= bus.in_gray;
            prev_ok   <= 1'b1;
         end
      end
   end else begin : g_nochk
      assign err0 = 1'b0;
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = v[LAST];
   assign bus.out_bin   = data[LAST];
   assign bus.out_err   = err[LAST];
endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Scoreboard bench for gray_to_bin_pipe: directed vectors on a 2-stage
// instance plus a full Gray sweep on 1-stage and 8-stage instances.
`timescale 1ns/1ps
module tb_gray_to_bin_pipe;
   typedef struct {
      logic [7:0] bin;
      logic       err;
      int         cyc;
      bit         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   int   stalls = 0;
   exp_t q2[$];
   exp_t q1[$];
   exp_t q8[$];

   gray_to_bin_pipe_if #(.WIDTH(8)) b2 ();
   gray_to_bin_pipe_if #(.WIDTH(8)) b1 ();
   gray_to_bin_pipe_if #(.WIDTH(8)) b8 ();

   gray_to_bin_pipe #(.WIDTH(8), .STAGES(2), .CHECK_EN(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   gray_to_bin_pipe #(.WIDTH(8), .STAGES(1), .CHECK_EN(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   gray_to_bin_pipe #(.WIDTH(8), .STAGES(8), .CHECK_EN(1'b1)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference decode: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b;
      logic [7:0] t;
      for (int i = 0; i < 8; i++) begin
         t    = g >> i;
         b[i] = ^t;
      end
      return b;
   endfunction

   task automatic send2(input logic [7:0] g, input logic [7:0] eb, input logic ee, input bit lat);
      int w = 0;
      exp_t e;
      b2.in_valid = 1'b1;
      b2.in_gray  = g;
      @(negedge clk);
      while (!b2.in_ready && w < 100) begin
         w++;
         stalls++;
         @(negedge clk);
      end
      if (!b2.in_ready) begin
         chk("s2_send_timeout", 64'(b2.in_ready), 64'd1);
      end else begin
         e.bin = eb; e.err = ee; e.cyc = cyc; e.lat = lat;
         q2.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_sw(input logic [7:0] g);
      int w = 0;
      exp_t e;
      b1.in_valid = 1'b1; b1.in_gray = g;
      b8.in_valid = 1'b1; b8.in_gray = g;
      @(negedge clk);
      while (!(b1.in_ready && b8.in_ready) && w < 100) begin
         w++;
         @(negedge clk);
      end
      if (!(b1.in_ready && b8.in_ready)) begin
         chk("sweep_send_timeout", {62'd0, b1.in_ready, b8.in_ready}, 64'd3);
      end else begin
         e.bin = g2b(g); e.err = 1'b0; e.cyc = cyc; e.lat = 1'b1;
         q1.push_back(e);
         q8.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle2();
      b2.in_valid = 1'b0;
      b2.in_gray  = 'x;
   endtask

   task automatic drain();
      int w = 0;
      while ((q2.size() + q1.size() + q8.size()) != 0 && w < 60) begin
         w++;
         @(posedge clk); #1;
      end
      chk("drain_pending", 64'(q2.size() + q1.size() + q8.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q2.delete(); q1.delete(); q8.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Output monitors: an output transfer happens at the next edge when valid & ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && b2.out_valid && b2.out_ready) begin
         if (q2.size() == 0) begin
            chk("s2_unexpected_word", 64'(b2.out_bin), 64'hDEAD);
         end else begin
            e = q2.pop_front();
            chk("s2_bin", 64'(b2.out_bin), 64'(e.bin));
            chk("s2_err", 64'(b2.out_err), 64'(e.err));
            if (e.lat) chk("s2_latency", 64'(cyc - e.cyc), 64'd2);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && b1.out_valid && b1.out_ready) begin
         if (q1.size() == 0) begin
            chk("s1_unexpected_word", 64'(b1.out_bin), 64'hDEAD);
         end else begin
            e = q1.pop_front();
            chk("s1_bin", 64'(b1.out_bin), 64'(e.bin));
            chk("s1_err", 64'(b1.out_err), 64'(e.err));
            if (e.lat) chk("s1_latency", 64'(cyc - e.cyc), 64'd1);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && b8.out_valid && b8.out_ready) begin
         if (q8.size() == 0) begin
            chk("s8_unexpected_word", 64'(b8.out_bin), 64'hDEAD);
         end else begin
            e = q8.pop_front();
            chk("s8_bin", 64'(b8.out_bin), 64'(e.bin));
            chk("s8_err", 64'(b8.out_err), 64'(e.err));
            if (e.lat) chk("s8_latency", 64'(cyc - e.cyc), 64'd8);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      b2.in_valid = 1'b0; b2.in_gray = '0; b2.out_ready = 1'b1;
      b1.in_valid = 1'b0; b1.in_gray = '0; b1.out_ready = 1'b1;
      b8.in_valid = 1'b0; b8.in_gray = '0; b8.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle2();

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 64'(b2.out_valid), 64'd0);
      chk("rst_out_bin",   64'(b2.out_bin),   64'd0);
      chk("rst_out_err",   64'(b2.out_err),   64'd0);
      chk("rst_in_ready",  64'(b2.in_ready),  64'd1);
      @(posedge clk); #1;

      // Single word, first after reset
      send2(8'hC0, 8'h80, 1'b0, 1'b1);
      idle2();
      drain();

      // Back-to-back stream from a fresh checker state
      do_reset();
      stalls = 0;
      send2(8'h00, 8'h00, 1'b0, 1'b1);
      send2(8'h01, 8'h01, 1'b0, 1'b1);
      send2(8'h03, 8'h02, 1'b0, 1'b1);
      send2(8'h02, 8'h03, 1'b0, 1'b1);
      chk("stream_in_ready_stalls", 64'(stalls), 64'd0);

      // Multi-bit change flag, then an MSB-only pattern
      send2(8'h00, 8'h00, 1'b0, 1'b1);
      send2(8'h03, 8'h02, 1'b1, 1'b1);
      send2(8'hC0, 8'h80, 1'b1, 1'b1);
      send2(8'h80, 8'hFF, 1'b0, 1'b1);
      idle2();
      drain();

      // Backpressure: two words fill the pipe, then in_ready must drop
      b2.out_ready = 1'b0;
      send2(8'h81, 8'hFE, 1'b0, 1'b0);
      send2(8'h83, 8'hFD, 1'b0, 1'b0);
      b2.in_valid = 1'b1;
      b2.in_gray  = 8'h82;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready",  64'(b2.in_ready),  64'd0);
         chk("bp_out_valid", 64'(b2.out_valid), 64'd1);
         chk("bp_out_bin",   64'(b2.out_bin),   64'hFE);
         chk("bp_out_err",   64'(b2.out_err),   64'd0);
      end
      @(posedge clk); #1;
      b2.out_ready = 1'b1;
      send2(8'h82, 8'hFC, 1'b0, 1'b0);
      send2(8'h86, 8'hFB, 1'b0, 1'b0);
      idle2();
      drain();

      // Mid-operation reset discards in-flight words and the checker history
      b2.out_ready = 1'b0;
      send2(8'h87, 8'hFA, 1'b0, 1'b0);
      send2(8'h85, 8'hF9, 1'b0, 1'b0);
      idle2();
      do_reset();
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(b2.out_valid), 64'd0);
      chk("mid_rst_out_bin",   64'(b2.out_bin),   64'd0);
      chk("mid_rst_out_err",   64'(b2.out_err),   64'd0);
      chk("mid_rst_in_ready",  64'(b2.in_ready),  64'd1);
      @(posedge clk); #1;
      b2.out_ready = 1'b1;
      send2(8'hFF, 8'hAA, 1'b0, 1'b1);
      idle2();
      drain();

      // Full Gray sweep on the single-stage and fully sliced instances
      for (int i = 0; i < 256; i++) begin
         logic [7:0] g;
         g = 8'(i) ^ (8'(i) >> 1);
         send_sw(g);
      end
      b1.in_valid = 1'b0;
      b8.in_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
